fetch_stage: RTL and testbench

Instruction-fetch stage of the br32 five-stage pipeline. Holds the program counter and issues word requests to instruction memory over a req/ack handshake. Presents fetched instructions to decode through a registered `if_out_t` bundle. Absorbs decode stalls with a one-entry skid buffer, and squashes wrong-path fetches when the execute stage redirects the PC.

---
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage.sv
// br32 instruction-fetch stage: PC, imem handshake, one-entry skid buffer and
// redirect squashing with a registered if_out_t bundle toward decode.
package pipeline_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] instr;
    logic        bubble;
  } if_out_t;
endpackage

// state | meaning
// FETCH | request outstanding at pc
// HOLD  | instruction parked in skid while decode stalls; no request
// DROP  | redirect arrived mid-request; waiting to discard the stale ack
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  fetch_stage_if.master          imem,
  output pipeline_pkg::if_out_t  out
);
  import pipeline_pkg::*;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } skid_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pending_pc, pending_pc_nxt;
  skid_t       skid, skid_nxt;
  if_out_t     out_nxt;
  logic [31:0] target;

  assign target    = redirect_pc & ~32'h0000_0003;
  assign imem.req  = (state != HOLD) && !rst;
  assign imem.addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pending_pc <= '0;
      skid       <= '0;
      out        <= '{pc: 32'h0, nextpc: 32'h0, instr: 32'h0, bubble: 1'b1};
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_pc_nxt;
      skid       <= skid_nxt;
      out        <= out_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pending_pc_nxt = pending_pc;
    skid_nxt       = skid;
    out_nxt        = out;

    if (redirect) begin
      // Squash overrides stall; the pc/addr pair must not move until an ack.
      out_nxt.bubble = 1'b1;
      unique case (state)
        FETCH: begin
          if (imem.ack) begin
            pc_nxt = target;
          end else begin
            pending_pc_nxt = target;
            state_nxt      = DROP;
          end
        end
        HOLD: begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end
        DROP: begin
          pending_pc_nxt = target;
          if (imem.ack) begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.ack) begin
            if (!stall) begin
              out_nxt = '{pc: pc, nextpc: pc + 32'd4, instr: imem.rdata, bubble: 1'b0};
              pc_nxt  = pc + 32'd4;
            end else begin
              skid_nxt  = '{pc: pc, instr: imem.rdata};
              state_nxt = HOLD;
            end
          end else if (!stall) begin
            out_nxt.bubble = 1'b1;
          end
        end
        HOLD: begin
          // pc still equals skid.pc here; it advances only on release.
          if (!stall) begin
            out_nxt   = '{pc: skid.pc, nextpc: skid.pc + 32'd4, instr: skid.instr, bubble: 1'b0};
            pc_nxt    = pc + 32'd4;
            state_nxt = FETCH;
          end
        end
        DROP: begin
          if (!stall) out_nxt.bubble = 1'b1;
          if (imem.ack) begin
            pc_nxt    = pending_pc;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: streaming, wait states, stall
// skid, redirect with/without ack, DROP retarget and PC wraparound.
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        stall2, redirect2;
  logic [31:0] redirect_pc2;
  if_out_t     out, out2;
  int          nchecks = 0;
  int          nerrors = 0;

  fetch_stage_if imem ();
  fetch_stage_if imem2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem), .out(out)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem(imem2), .out(out2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] p, input logic [31:0] instr);
    chk({tag, ".pc"}, out.pc, p);
    chk({tag, ".nextpc"}, out.nextpc, p + 32'd4);
    chk({tag, ".instr"}, out.instr, instr);
    chk({tag, ".bubble"}, {31'b0, out.bubble}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    imem.ack = 1'b0; imem.rdata = '0; imem2.ack = 1'b0; imem2.rdata = '0;
    tick(); tick();

    chk("rst.req", {31'b0, imem.req}, 32'd0);
    chk("rst.bubble", {31'b0, out.bubble}, 32'd1);
    chk("rst.out_pc", out.pc, 32'h0);
    chk("rst.out_instr", out.instr, 32'h0);
    chk("rst.addr", imem.addr, 32'h0);
    chk("rst.addr2", imem2.addr, 32'hFFFF_FFFC);

    rst = 1'b0;
    #1;
    chk("first.req", {31'b0, imem.req}, 32'd1);
    chk("first.addr", imem.addr, 32'h0);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      imem.ack = 1'b1; imem.rdata = imem.addr ^ K;
      tick();
      chk_out("stream", 32'(4 * i), 32'(4 * i) ^ K);
      chk("stream.addr", imem.addr, 32'(4 * (i + 1)));
    end

    // two wait cycles before ack at 16
    imem.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wait.bubble", {31'b0, out.bubble}, 32'd1);
      chk("wait.addr", imem.addr, 32'h10);
      chk("wait.req", {31'b0, imem.req}, 32'd1);
    end
    imem.ack = 1'b1; imem.rdata = 32'h10 ^ K;
    tick();
    chk_out("wait.deliver", 32'h10, 32'h10 ^ K);
    chk("wait.next_addr", imem.addr, 32'h14);

    // stall for 3 cycles with ack arriving on the first
    stall = 1'b1; imem.ack = 1'b1; imem.rdata = 32'h14 ^ K;
    tick();
    imem.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.req", {31'b0, imem.req}, 32'd0);
      chk_out("stall.hold", 32'h10, 32'h10 ^ K);
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    chk_out("stall.release", 32'h14, 32'h14 ^ K);
    chk("stall.next_addr", imem.addr, 32'h18);
    chk("stall.next_req", {31'b0, imem.req}, 32'd1);

    // redirect with ack: rdata discarded, target aligned
    imem.ack = 1'b1; imem.rdata = 32'h18 ^ K; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("redir_ack.bubble", {31'b0, out.bubble}, 32'd1);
    chk("redir_ack.addr", imem.addr, 32'h100);
    imem.ack = 1'b1; imem.rdata = 32'h100 ^ K;
    tick();
    chk_out("redir_ack.target", 32'h100, 32'h100 ^ K);

    // redirect without ack: addr parked on old pc until stale ack
    imem.ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("drop.bubble", {31'b0, out.bubble}, 32'd1);
    chk("drop.addr0", imem.addr, 32'h104);
    tick();
    chk("drop.addr1", imem.addr, 32'h104);
    chk("drop.req", {31'b0, imem.req}, 32'd1);
    imem.ack = 1'b1; imem.rdata = 32'h104 ^ K;
    tick();
    chk("drop.bubble_stale", {31'b0, out.bubble}, 32'd1);
    chk("drop.addr_target", imem.addr, 32'h200);
    imem.ack = 1'b1; imem.rdata = 32'h200 ^ K;
    tick();
    chk_out("drop.target", 32'h200, 32'h200 ^ K);

    // second redirect in DROP coinciding with the stale ack wins
    imem.ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    chk("drop2.addr", imem.addr, 32'h204);
    imem.ack = 1'b1; imem.rdata = 32'h204 ^ K; redirect_pc = 32'h3FF;
    tick();
    redirect = 1'b0;
    chk("drop2.addr_target", imem.addr, 32'h3FC);
    chk("drop2.bubble", {31'b0, out.bubble}, 32'd1);
    imem.ack = 1'b1; imem.rdata = 32'h3FC ^ K;
    tick();
    chk_out("drop2.target", 32'h3FC, 32'h3FC ^ K);

    // redirect overrides stall
    stall = 1'b1; imem.ack = 1'b1; imem.rdata = 32'h400 ^ K; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; imem.ack = 1'b0; stall = 1'b0;
    chk("redir_stall.bubble", {31'b0, out.bubble}, 32'd1);
    chk("redir_stall.addr", imem.addr, 32'h40);

    // wraparound on the second instance
    chk("wrap.addr_pre", imem2.addr, 32'hFFFF_FFFC);
    imem2.ack = 1'b1; imem2.rdata = 32'hFFFF_FFFC ^ K;
    tick();
    imem2.ack = 1'b0;
    chk("wrap.out_pc", out2.pc, 32'hFFFF_FFFC);
    chk("wrap.nextpc", out2.nextpc, 32'h0);
    chk("wrap.bubble", {31'b0, out2.bubble}, 32'd0);
    chk("wrap.addr", imem2.addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
